// File: rtl/march_pkg.sv
// Shared widths and FSM state encoding for the ram512 March C- tester.
package march_pkg;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W0_UP   = 3'd1,
        R0W1_UP = 3'd2,
        R1W0_DN = 3'd3,
        R0_DN   = 3'd4,
        FINISH  = 3'd5
    } state_e;
endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for the March sweep.
// Latency: 1 cycle from load/en to addr. No backpressure; at_end flags the last address in the current direction.
module march_addr_gen
    import march_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              dir,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              at_end
);
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (en) begin
            addr_d = dir ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // dir=1 counts down, so the sweep ends at 0; ascending sweeps end at all-ones.
    assign at_end = dir ? (addr_q == '0) : (addr_q == '1);
    assign addr   = addr_q;
endmodule

// File: rtl/ram512_march_tester.sv
// March C- built-in self-test initiator for ram512 (combinational-read RAM).
// Latency: 3072 active cycles fault-free; done 3073 edges after start. No backpressure; start ignored while busy.
module ram512_march_tester
    import march_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] fail_exp
);
    state_e            state_q, state_d;
    logic              phase_q, phase_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic              done_q, done_d, pass_q, pass_d, fail_seen_q, fail_seen_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d, fail_exp_q, fail_exp_d;
    logic              cnt_load, cnt_dir, cnt_en, at_end, is_read;
    logic [ADDR_W-1:0] cnt_val;
    logic [DATA_W-1:0] exp_w;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dir      (cnt_dir),
        .en       (cnt_en),
        .addr     (mem_address),
        .at_end   (at_end)
    );

    assign cnt_dir = (state_q == R1W0_DN) || (state_q == R0_DN);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pattern_d   = pattern_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_seen_d = fail_seen_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_exp_d  = fail_exp_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_en      = 1'b0;
        mem_load    = 1'b0;
        mem_in      = '0;
        busy        = 1'b0;
        is_read     = 1'b0;
        exp_w       = pattern_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pattern_d   = pattern;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_seen_d = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_exp_d  = '0;
                    cnt_load    = 1'b1;
                    phase_d     = 1'b0;
                    state_d     = W0_UP;
                end
            end
            W0_UP: begin
                busy     = 1'b1;
                mem_load = 1'b1;
                mem_in   = pattern_q;
                if (at_end) begin
                    cnt_load = 1'b1;
                    state_d  = R0W1_UP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            R0W1_UP, R1W0_DN: begin
                busy = 1'b1;
                if (!phase_q) begin
                    is_read = 1'b1;
                    exp_w   = (state_q == R0W1_UP) ? pattern_q : ~pattern_q;
                    phase_d = 1'b1;
                end else begin
                    mem_load = 1'b1;
                    mem_in   = (state_q == R0W1_UP) ? ~pattern_q : pattern_q;
                    phase_d  = 1'b0;
                    if (at_end) begin
                        cnt_load = 1'b1;
                        cnt_val  = '1;
                        state_d  = (state_q == R0W1_UP) ? R1W0_DN : R0_DN;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            R0_DN: begin
                busy    = 1'b1;
                is_read = 1'b1;
                if (at_end) begin
                    state_d = FINISH;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                pass_d  = !fail_seen_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A failed read aborts the run before its paired write can be issued.
        if (is_read && (mem_out != exp_w)) begin
            fail_seen_d = 1'b1;
            fail_addr_d = mem_address;
            fail_data_d = mem_out;
            fail_exp_d  = exp_w;
            phase_d     = 1'b0;
            cnt_en      = 1'b0;
            cnt_load    = 1'b0;
            state_d     = FINISH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            pattern_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pattern_q   <= pattern_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_seen_q <= fail_seen_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_exp  = fail_exp_q;
endmodule

// File: tb/tb_ram512_march_tester.sv
// Scoreboard bench for ram512_march_tester with a fault-injectable RAM model.
module tb_ram512_march_tester;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic        mem_load, busy, done, pass;
    logic [8:0]  mem_address, fail_addr;
    logic [15:0] mem_in, mem_out, fail_data, fail_exp;

    ram512_march_tester dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .mem_load(mem_load), .mem_address(mem_address), .mem_in(mem_in),
        .mem_out(mem_out), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_exp(fail_exp)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [512];
    logic [8:0]  f_addr = '0;
    logic [15:0] f_set = '0, f_clr = '0;
    logic [8:0]  watch_addr = 9'd2;

    always @(posedge clk) if (rst_n && mem_load) ram[mem_address] <= mem_in;

    always_comb begin
        mem_out = ram[mem_address];
        if (mem_address == f_addr) mem_out = (ram[mem_address] | f_set) & ~f_clr;
    end

    typedef struct {
        int pass; int fa; int fd; int fe;
        int busy_cyc; int reads; int writes; int watch_wr;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic exp_t mk(int p, int fa, int fd, int fe, int bc, int rd, int wr, int ww);
        exp_t e;
        e.pass = p; e.fa = fa; e.fd = fd; e.fe = fe;
        e.busy_cyc = bc; e.reads = rd; e.writes = wr; e.watch_wr = ww;
        return e;
    endfunction

    // Monitor: counts bus activity per run and scores each result when done rises.
    int busy_cyc, n_rd, n_wr, n_watch, order_err;
    logic prev_busy, prev_load, done_prev;
    logic [8:0] prev_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cyc = 0; n_rd = 0; n_wr = 0; n_watch = 0; order_err = 0;
            prev_busy = 1'b0; prev_load = 1'b0; prev_addr = '0; done_prev = 1'b0;
        end else begin
            if (busy) begin
                busy_cyc++;
                if (mem_load) begin
                    n_wr++;
                    if (mem_address == watch_addr) n_watch++;
                    if (prev_busy && !prev_load && mem_address != prev_addr) order_err++;
                end else begin
                    n_rd++;
                end
            end
            prev_busy = busy; prev_load = mem_load; prev_addr = mem_address;
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=done required=no_result_pending");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pass", int'(pass), e.pass);
                    chk("fail_addr", int'(fail_addr), e.fa);
                    chk("fail_data", int'(fail_data), e.fd);
                    chk("fail_exp", int'(fail_exp), e.fe);
                    chk("busy_cycles", busy_cyc, e.busy_cyc);
                    chk("read_cycles", n_rd, e.reads);
                    chk("write_cycles", n_wr, e.writes);
                    chk("watch_writes", n_watch, e.watch_wr);
                    chk("write_after_read_order", order_err, 0);
                    chk("busy_at_done", int'(busy), 0);
                end
                busy_cyc = 0; n_rd = 0; n_wr = 0; n_watch = 0; order_err = 0;
            end
            done_prev = done;
        end
    end

    task automatic run(input logic [15:0] p, input bit poke);
        @(negedge clk);
        pattern = p;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        chk("accept_done_clr", int'(done), 0);
        chk("accept_pass_clr", int'(pass), 0);
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            start = (poke && (i == 100 || i == 2000)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=done_low required=done_high");
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_mem_load", int'(mem_load), 0);
        chk("rst_mem_address", int'(mem_address), 0);
        chk("rst_mem_in", int'(mem_in), 0);
        chk("rst_fail_addr", int'(fail_addr), 0);
        chk("rst_fail_data", int'(fail_data), 0);
        chk("rst_fail_exp", int'(fail_exp), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free run
        sb.push_back(mk(1, 0, 0, 0, 3072, 1536, 1536, 3));
        run(16'habcd, 1'b0);
        chk("ram_word2", int'(ram[2]), 16'habcd);
        chk("ram_word511", int'(ram[511]), 16'habcd);

        // Word 2 bit 0 stuck at 1: caught at the first ascending read of word 2
        f_addr = 9'd2; f_set = 16'h0001; f_clr = 16'h0000; watch_addr = 9'd2;
        sb.push_back(mk(0, 2, 16'h0001, 16'h0000, 517, 3, 514, 1));
        run(16'h0000, 1'b0);

        // Word 511 bit 15 stuck at 0: only visible when ~P is read back descending
        f_addr = 9'd511; f_set = 16'h0000; f_clr = 16'h8000; watch_addr = 9'd511;
        sb.push_back(mk(0, 511, 16'h7fff, 16'hffff, 1537, 513, 1024, 2));
        run(16'h0000, 1'b0);

        f_clr = 16'h0000; watch_addr = 9'd2;
        // start pulses while busy must not restart the run
        sb.push_back(mk(1, 0, 0, 0, 3072, 1536, 1536, 3));
        run(16'h5a5a, 1'b1);
        // second start after done clears done/pass and reruns
        sb.push_back(mk(1, 0, 0, 0, 3072, 1536, 1536, 3));
        run(16'h1234, 1'b0);

        // Abort mid R0W1_UP with asynchronous reset
        @(negedge clk);
        pattern = 16'h0f0f;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (700) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_mem_load", int'(mem_load), 0);
        chk("abort_mem_address", int'(mem_address), 0);
        chk("abort_mem_in", int'(mem_in), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_write", int'(mem_load), 0);
        end
        rst_n = 1'b1;
        sb.push_back(mk(1, 0, 0, 0, 3072, 1536, 1536, 3));
        run(16'hc3c3, 1'b0);
        chk("ram_word511_after_rerun", int'(ram[511]), 16'hc3c3);

        chk("scoreboard_leftover", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
